// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU into HI/LO plus MTHI/MTLO; optional sticky div0 flag under MDU_DIV0_FLAG_EN.
// Latency WIDTH+1 edges start-to-result; busy stalls the issuer and all inputs are ignored while busy.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef MDU_DIV0_FLAG_EN
    ,
    output logic             div0
`endif
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic               isDiv;
    logic               negRes;
    logic               negRem;
    logic [WIDTH-1:0]   opA;
    logic [WIDTH-1:0]   opB;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;

    logic             signA;
    logic             signB;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;

    assign signA = ~op[0] & busA[WIDTH-1];
    assign signB = ~op[0] & busB[WIDTH-1];
    assign absA  = signA ? -busA : busA;
    assign absB  = signB ? -busB : busB;

    // Multiply: acc = {partial product, remaining multiplier bits}
    logic [WIDTH:0] mulSum;
    assign mulSum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opA} : '0);

    // Divide: acc[WIDTH-1:0] shifts dividend bits out and quotient bits in
    logic [WIDTH:0] remShift;
    logic [WIDTH:0] remDiff;
    assign remShift = {rem, acc[WIDTH-1]};
    assign remDiff  = remShift - {1'b0, opB};

    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quotFix;
    logic [WIDTH-1:0]   remFix;
    logic [WIDTH-1:0]   rawA;
    logic               divZero;

    assign prodFix = negRes ? -acc : acc;
    assign quotFix = negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign remFix  = negRem ? -rem : rem;
    assign rawA    = negRem ? -opA : opA;
    assign divZero = (opB == '0);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state  <= IDLE;
            count  <= '0;
            isDiv  <= 1'b0;
            negRes <= 1'b0;
            negRem <= 1'b0;
            opA    <= '0;
            opB    <= '0;
            acc    <= '0;
            rem    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
`ifdef MDU_DIV0_FLAG_EN
            div0   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        isDiv  <= op[1];
                        negRes <= signA ^ signB;
                        negRem <= signA;
                        opA    <= absA;
                        opB    <= absB;
                        acc    <= {{WIDTH{1'b0}}, (op[1] ? absA : absB)};
                        rem    <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= op[1] ? DIV : MUL;
`ifdef MDU_DIV0_FLAG_EN
                        div0   <= 1'b0;
`endif
                    end else begin
                        if (mthi) hi <= busA;
                        if (mtlo) lo <= busA;
                    end
                end
                MUL: begin
                    acc   <= {mulSum, acc[WIDTH-1:1]};
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH-1)) state <= FIX;
                end
                DIV: begin
                    if (!remDiff[WIDTH]) begin
                        rem                <= remDiff[WIDTH-1:0];
                        acc[WIDTH-1:0]     <= {acc[WIDTH-2:0], 1'b1};
                    end else begin
                        rem                <= remShift[WIDTH-1:0];
                        acc[WIDTH-1:0]     <= {acc[WIDTH-2:0], 1'b0};
                    end
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH-1)) state <= FIX;
                end
                FIX: begin
                    if (isDiv) begin
                        // Zero divisor reports the untouched dividend in HI
                        if (divZero) begin
                            lo <= '1;
                            hi <= rawA;
`ifdef MDU_DIV0_FLAG_EN
                            div0 <= 1'b1;
`endif
                        end else begin
                            lo <= quotFix;
                            hi <= remFix;
                        end
                    end else begin
                        hi <= prodFix[2*WIDTH-1:WIDTH];
                        lo <= prodFix[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written corner sequences, random ops vs a plain-arithmetic model.
module tb_mult_div_unit;
    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST_n = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] busA = '0;
    logic [W-1:0] busB = '0;
    logic         mthi = 1'b0;
    logic         mtlo = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
`ifdef MDU_DIV0_FLAG_EN
    logic         div0;
`endif

    int compared = 0;
    int mismatched = 0;
    logic [W-1:0] curHi = '0;
    logic [W-1:0] curLo = '0;

    mult_div_unit #(.WIDTH(W)) dut (
        .CLK(CLK), .RST_n(RST_n), .start(start), .op(op), .busA(busA), .busB(busB),
        .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .hi(hi), .lo(lo)
`ifdef MDU_DIV0_FLAG_EN
        , .div0(div0)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] expHi;
        logic [W-1:0] expLo;
    } vec_t;

    vec_t vec[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: signed/unsigned 64-bit arithmetic; SV / and % truncate toward zero
    task automatic model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] eh, output logic [W-1:0] el);
        longint sa, sb, sp, sq, sr;
        logic [63:0] ua, ub, up, uq, ur;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        eh = '0;
        el = '0;
        case (o)
            2'b00: begin sp = sa * sb; up = sp; eh = up[63:32]; el = up[31:0]; end
            2'b01: begin up = ua * ub; eh = up[63:32]; el = up[31:0]; end
            2'b10: begin
                if (b == 0) begin el = '1; eh = a; end
                else begin
                    sq = sa / sb; sr = sa % sb;
                    uq = sq; ur = sr;
                    el = uq[31:0]; eh = ur[31:0];
                end
            end
            default: begin
                if (b == 0) begin el = '1; eh = a; end
                else begin
                    uq = ua / ub; ur = ua % ub;
                    el = uq[31:0]; eh = ur[31:0];
                end
            end
        endcase
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the start edge
    task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1; op = o; busA = a; busB = b;
        @(negedge CLK);
        start = 1'b0; op = 2'($urandom); busA = $urandom; busB = $urandom;
    endtask

    // Returns at the negedge inside the done cycle (or after the budget expires)
    task automatic waitDone(output int busyCyc, output bit seen, output int holdBad);
        busyCyc = 0; seen = 1'b0; holdBad = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (busy) busyCyc++;
            if (done) seen = 1'b1;
            else begin
                if (hi !== curHi || lo !== curLo) holdBad++;
                @(negedge CLK);
            end
        end
    endtask

    initial begin
        int cyc, holdBad, doneCnt;
        bit seen;
        logic [W-1:0] eh, el;
        logic [1:0] o;
        logic [W-1:0] a, b;

        #2 RST_n = 1'b0;
        repeat (2) @(negedge CLK);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
`ifdef MDU_DIV0_FLAG_EN
        chk("reset_div0", div0, 0);
`endif
        RST_n = 1'b1;
        @(negedge CLK);

        vec[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vec[1] = '{2'b00, 32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFFF, 32'hFFFF_FFD6};
        vec[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vec[3] = '{2'b11, 32'd100,       32'h0,         32'h0000_0064, 32'hFFFF_FFFF};
        vec[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vec[5] = '{2'b11, 32'd50,        32'd7,         32'h0000_0001, 32'h0000_0007};
        vec[6] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vec[7] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vec[8] = '{2'b10, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};

        // Back-to-back: each start is raised during the previous done cycle
        for (int i = 0; i < 9; i++) begin
            launch(vec[i].op, vec[i].a, vec[i].b);
            chk($sformatf("v%0d_done_low_after_start", i), done, 0);
            chk($sformatf("v%0d_busy_after_start", i), busy, 1);
`ifdef MDU_DIV0_FLAG_EN
            chk($sformatf("v%0d_div0_cleared", i), div0, 0);
`endif
            waitDone(cyc, seen, holdBad);
            chk($sformatf("v%0d_done_seen", i), seen, 1);
            chk($sformatf("v%0d_busy_cycles", i), cyc, 33);
            chk($sformatf("v%0d_hold", i), holdBad, 0);
            chk($sformatf("v%0d_hi", i), hi, vec[i].expHi);
            chk($sformatf("v%0d_lo", i), lo, vec[i].expLo);
            chk($sformatf("v%0d_busy_at_done", i), busy, 0);
`ifdef MDU_DIV0_FLAG_EN
            chk($sformatf("v%0d_div0", i), div0, (vec[i].op[1] && vec[i].b == 0));
`endif
            curHi = vec[i].expHi;
            curLo = vec[i].expLo;
        end
        @(negedge CLK);
        chk("done_single_pulse", done, 0);

`ifdef MDU_DIV0_FLAG_EN
        launch(2'b11, 32'd100, 32'd0);
        waitDone(cyc, seen, holdBad);
        curHi = 32'd100; curLo = '1;
        repeat (5) @(negedge CLK);
        chk("div0_sticky_idle", div0, 1);
        launch(2'b01, 32'd2, 32'd3);
        chk("div0_clear_on_start", div0, 0);
        waitDone(cyc, seen, holdBad);
        chk("div0_stays_clear", div0, 0);
        curHi = 0; curLo = 32'd6;
        @(negedge CLK);
`endif

        // Register moves in IDLE
        mthi = 1'b1; busA = 32'h1234_5678;
        @(negedge CLK);
        mthi = 1'b0;
        chk("mthi_hi", hi, 32'h1234_5678);
        chk("mthi_lo_unchanged", lo, curLo);
        curHi = 32'h1234_5678;
        mtlo = 1'b1; busA = 32'hAABB_CCDD;
        @(negedge CLK);
        mtlo = 1'b0;
        chk("mtlo_lo", lo, 32'hAABB_CCDD);
        chk("mtlo_hi_unchanged", hi, curHi);
        curLo = 32'hAABB_CCDD;
        mthi = 1'b1; mtlo = 1'b1; busA = 32'h0F0F_0F0F;
        @(negedge CLK);
        mthi = 1'b0; mtlo = 1'b0;
        chk("mthilo_hi", hi, 32'h0F0F_0F0F);
        chk("mthilo_lo", lo, 32'h0F0F_0F0F);
        curHi = 32'h0F0F_0F0F; curLo = 32'h0F0F_0F0F;

        // start beats simultaneous moves; moves held high during the op are ignored
        mthi = 1'b1; mtlo = 1'b1;
        launch(2'b01, 32'd3, 32'd5);
        chk("start_wins_hi", hi, curHi);
        chk("start_wins_lo", lo, curLo);
        repeat (10) @(negedge CLK);
        chk("mtlo_busy_lo", lo, curLo);
        chk("mthi_busy_hi", hi, curHi);
        mthi = 1'b0; mtlo = 1'b0;
        waitDone(cyc, seen, holdBad);
        chk("moves_op_done", seen, 1);
        chk("moves_op_hi", hi, 0);
        chk("moves_op_lo", lo, 32'd15);
        @(negedge CLK);

        // Reset mid-divide aborts with no result and no done
        launch(2'b11, 32'd50, 32'd7);
        repeat (9) @(negedge CLK);
        RST_n = 1'b0;
        #1;
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(negedge CLK);
        RST_n = 1'b1;
        doneCnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) doneCnt++;
            @(negedge CLK);
        end
        chk("abort_no_done_or_busy", doneCnt, 0);
        chk("abort_hi_held", hi, 0);
        curHi = 0; curLo = 0;
        launch(2'b11, 32'd50, 32'd7);
        waitDone(cyc, seen, holdBad);
        chk("fresh_done", seen, 1);
        chk("fresh_lo", lo, 32'd7);
        chk("fresh_hi", hi, 32'd1);
        curHi = 32'd1; curLo = 32'd7;

        // Random back-to-back ops against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = pick();
            b = pick();
            model(o, a, b, eh, el);
            launch(o, a, b);
            waitDone(cyc, seen, holdBad);
            chk($sformatf("rnd%0d_done op=%0d a=%h b=%h", i, o, a, b), seen, 1);
            chk($sformatf("rnd%0d_cycles", i), cyc, 33);
            chk($sformatf("rnd%0d_hold", i), holdBad, 0);
            chk($sformatf("rnd%0d_hi op=%0d a=%h b=%h", i, o, a, b), hi, eh);
            chk($sformatf("rnd%0d_lo op=%0d a=%h b=%h", i, o, a, b), lo, el);
            curHi = eh; curLo = el;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit sitting directly downstream of the register file.
- Consumes busA (rs) and busB (rt) and executes MULT, MULTU, DIV and DIVU into private HI/LO registers.
- Also services MTHI/MTLO writes; HI/LO are read back by the writeback mux for MFHI/MFLO.
- Uses a start/busy/done handshake so the controller stalls while an operation is in progress.

Parameters:
- WIDTH, 32, operand width. HI, LO, busA and busB are all WIDTH bits. Iteration count equals WIDTH.

Ports:
- CLK  input  1  clock; all state changes on posedge.
- RST_n  input  1  asynchronous, active-low reset.
- start  input  1  request an operation; sampled only in IDLE.
- op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- busA  input  WIDTH  rs operand: multiplicand / dividend / MTHI-MTLO data.
- busB  input  WIDTH  rt operand: multiplier / divisor.
- mthi  input  1  write busA into HI.
- mtlo  input  1  write busA into LO.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when HI/LO are updated by an operation.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (RST_n low, asynchronous):
  - State goes to IDLE.
  - hi = 0, lo = 0, busy = 0, done = 0; counter and internal accumulators cleared.
  - Reset asserted mid-operation aborts it; no partial result reaches HI/LO.
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - start=1 at edge E0: latch op; latch |busA| and |busB| (absolute values for signed ops, raw values for unsigned ops); record result signs; counter = 0.
  - Then go to MUL (op[1]=0) or DIV (op[1]=1). busy = 1 from E0.
  - start=0 with mthi/mtlo: write hi/lo from busA at that edge. mthi and mtlo together write both.
  - start and mthi/mtlo together: start wins; the moves are ignored.
- MUL:
  - Shift-add, one multiplier bit per edge (E1..E_WIDTH).
  - 2*WIDTH-bit accumulator.
- DIV:
  - Restoring divide, one quotient bit per edge (E1..E_WIDTH).
  - WIDTH+1-bit partial remainder.
- Transition: after counter reaches WIDTH-1, go to FIX.
- FIX (edge E_WIDTH+1):
  - Apply sign correction.
  - Write hi/lo: MUL gives hi = upper half, lo = lower half of the product. DIV gives lo = quotient, hi = remainder.
  - done = 1 for exactly this one cycle; busy = 0; return to IDLE.
  - Total latency: start edge to result edge = WIDTH+1 edges (33 for WIDTH=32).
- Signed rules:
  - Product negated if operand signs differ.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - -2^31 / -1 gives lo = 0x80000000, hi = 0.
- Divide by zero (busB = 0 at start):
  - Same latency as a normal divide.
  - Result forced to lo = all-ones, hi = busA as latched (unsigned dividend value, i.e. original busA).
- Inputs ignored while busy: start, op, busA, busB, mthi and mtlo. hi/lo hold their previous values until FIX.
- A new start is accepted in the cycle immediately after done (back-to-back operation).

Optional Feature:
- Macro: MDU_DIV0_FLAG_EN.
- When defined:
  - Adds output port div0 (1 bit, reset 0).
  - div0 is a sticky flag, set at the FIX edge of a divide whose latched divisor was 0.
  - Cleared by the next accepted start or by reset.
- When undefined: port absent; divide-by-zero behaviour otherwise identical.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 33 edges: hi = 0xFFFFFFFE, lo = 0x00000001; done pulses once; busy high for exactly 33 cycles.
- MULT -7 x 6 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFD6. Then back-to-back DIV -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIVU 100 / 0 -> lo = 0xFFFFFFFF, hi = 0x00000064; with MDU_DIV0_FLAG_EN, div0 = 1 until the next start.
- DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- MTHI 0x12345678 in IDLE -> hi updated next edge, lo unchanged. MTLO pulsed while busy -> lo unaffected; final lo = operation result.
- Assert RST_n low at cycle 10 of a DIVU 50 / 7 -> hi = lo = 0, busy = 0, no done pulse. Fresh DIVU 50 / 7 -> lo = 7, hi = 1.
